// File: rtl/dda_pkg.sv
// Shared definitions for the DDA command feeder: defaults, command layout and
// feeder FSM states.
package dda_pkg;

    localparam int unsigned NMAX_DEF   = 50;
    localparam int unsigned PERIOD_DEF = 20000;

    typedef struct packed {
        logic       dir;
        logic [6:0] mag;
    } dda_cmd_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_LOAD,
        S_STROBE
    } feed_state_t;

endpackage

// File: rtl/feeder_fifo.sv
// Synchronous DEPTH x 8 FIFO with registered level/full/empty; a push is
// accepted while full when a pop happens in the same cycle.
module feeder_fifo #(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    wr_data,
    output logic [7:0]    rd_data,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;
    logic [AW:0]   level_next;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_comb begin
        level_next = level;
        case ({do_push, do_pop})
            2'b10:   level_next = level + 1'b1;
            2'b01:   level_next = level - 1'b1;
            default: level_next = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            level <= level_next;
            full  <= (level_next == (AW + 1)'(DEPTH));
            empty <= (level_next == '0);
        end
    end

endmodule

// File: rtl/dda_feeder.sv
// Periodic command feeder for the DDA: buffers host writes and issues one
// clamped command plus a load strobe per control period.
module dda_feeder
    import dda_pkg::*;
#(
    parameter int unsigned PERIOD = PERIOD_DEF,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned WR_LEN = 4,
    parameter int unsigned NMAX   = NMAX_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run,
    input  logic [7:0]             host_data,
    input  logic                   host_wr,
    input  logic                   clr_flags,
    input  logic                   dda_busy,
    output logic [7:0]             dda_n,
    output logic                   dda_wr,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   fifo_full,
    output logic                   fifo_empty,
    output logic                   overflow,
    output logic                   underrun,
    output logic                   late,
    output logic                   clamped
);

    localparam int unsigned TW = $clog2(PERIOD);
    localparam int unsigned CW = $clog2(WR_LEN + 1);
    localparam logic [TW-1:0] T_LAST  = TW'(PERIOD - 1);
    localparam logic [CW-1:0] C_LAST  = CW'(WR_LEN);
    localparam logic [6:0]    MAG_MAX = 7'(NMAX);

    feed_state_t   state;
    logic [TW-1:0] timer;
    logic [CW-1:0] wr_cnt;
    logic [2:0]    wr_sync;
    logic          push;
    logic          pop;
    logic          tick;
    logic [7:0]    head;
    dda_cmd_t      head_cmd;
    dda_cmd_t      load_cmd;
    logic          over_limit;

    assign push = wr_sync[1] & ~wr_sync[2];
    assign pop  = (state == S_LOAD);
    assign tick = (timer == T_LAST);

    feeder_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .wr_data (host_data),
        .rd_data (head),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        head_cmd   = dda_cmd_t'(head);
        over_limit = (head_cmd.mag > MAG_MAX);
        load_cmd   = head_cmd;
        if (fifo_empty)
            load_cmd = '0;
        else if (over_limit)
            load_cmd.mag = MAG_MAX;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wr_sync <= '0;
        else
            wr_sync <= {wr_sync[1:0], host_wr};
    end

    // Timer free-runs outside IDLE so LOAD/STROBE do not stretch the period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            timer  <= '0;
            wr_cnt <= '0;
            dda_n  <= '0;
            dda_wr <= 1'b0;
        end else begin
            timer <= tick ? '0 : timer + 1'b1;
            case (state)
                S_IDLE: begin
                    timer <= '0;
                    if (run)
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!run) begin
                        state <= S_IDLE;
                        timer <= '0;
                    end else if (tick) begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    dda_n  <= load_cmd;
                    wr_cnt <= '0;
                    state  <= S_STROBE;
                end
                S_STROBE: begin
                    if (wr_cnt == C_LAST) begin
                        dda_wr <= 1'b0;
                        if (run) begin
                            state <= S_WAIT;
                        end else begin
                            state <= S_IDLE;
                            timer <= '0;
                        end
                    end else begin
                        dda_wr <= 1'b1;
                        wr_cnt <= wr_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            underrun <= 1'b0;
            late     <= 1'b0;
            clamped  <= 1'b0;
        end else begin
            if (push && fifo_full && !pop)
                overflow <= 1'b1;
            else if (clr_flags)
                overflow <= 1'b0;
            if (pop && fifo_empty)
                underrun <= 1'b1;
            else if (clr_flags)
                underrun <= 1'b0;
            if (pop && dda_busy)
                late <= 1'b1;
            else if (clr_flags)
                late <= 1'b0;
            if (pop && !fifo_empty && over_limit)
                clamped <= 1'b1;
            else if (clr_flags)
                clamped <= 1'b0;
        end
    end

endmodule
